// File: rtl/idma_mp_rsp_merge.sv
// Collects per-back-end completions for each issued transfer, in issue order, and
// emits one merged response per transfer with the targeted back-ends' errors OR-combined.
module idma_mp_rsp_merge #(
  parameter int unsigned NumBEs     = 4,
  parameter int unsigned IssueDepth = 4,
  parameter int unsigned BeRspDepth = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumBEs-1:0] issue_mask_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [NumBEs-1:0] be_rsp_error_i,
  input  logic [NumBEs-1:0] be_rsp_valid_i,
  output logic [NumBEs-1:0] be_rsp_ready_o,
  output logic              rsp_error_o,
  output logic [NumBEs-1:0] rsp_err_mask_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              busy_o
);

  localparam int unsigned IssPtrW = (IssueDepth > 1) ? $clog2(IssueDepth) : 1;
  localparam int unsigned IssCntW = $clog2(IssueDepth + 1);
  localparam int unsigned BePtrW  = (BeRspDepth > 1) ? $clog2(BeRspDepth) : 1;
  localparam int unsigned BeCntW  = $clog2(BeRspDepth + 1);
  localparam logic [IssCntW-1:0] IssFullCnt = IssCntW'(IssueDepth);
  localparam logic [BeCntW-1:0]  BeFullCnt  = BeCntW'(BeRspDepth);

  // Pointers wrap explicitly so depths need not be powers of two.
  function automatic logic [IssPtrW-1:0] iss_ptr_inc(input logic [IssPtrW-1:0] p);
    return (p == IssPtrW'(IssueDepth - 1)) ? '0 : p + IssPtrW'(1);
  endfunction

  function automatic logic [BePtrW-1:0] be_ptr_inc(input logic [BePtrW-1:0] p);
    return (p == BePtrW'(BeRspDepth - 1)) ? '0 : p + BePtrW'(1);
  endfunction

  logic [NumBEs-1:0]  iss_mem [IssueDepth];
  logic [IssPtrW-1:0] iss_wr_ptr, iss_rd_ptr;
  logic [IssCntW-1:0] iss_cnt;
  logic               iss_full, iss_empty, iss_push, iss_pop;
  logic [NumBEs-1:0]  head_mask;

  logic               be_mem [NumBEs][BeRspDepth];
  logic [BePtrW-1:0]  be_wr_ptr [NumBEs];
  logic [BePtrW-1:0]  be_rd_ptr [NumBEs];
  logic [BeCntW-1:0]  be_cnt [NumBEs];
  logic [NumBEs-1:0]  be_full, be_nonempty, be_push, be_pop, head_err;

  logic               out_free, merge;
  logic [NumBEs-1:0]  merge_mask;
  logic               rsp_vld_p1, rsp_err_p1;
  logic [NumBEs-1:0]  rsp_mask_p1;

  // ---- stage p0: FIFO status and merge decision ----
  assign iss_full      = (iss_cnt == IssFullCnt);
  assign iss_empty     = (iss_cnt == '0);
  assign issue_ready_o = !iss_full;
  assign iss_push      = issue_valid_i && !iss_full;
  assign head_mask     = iss_mem[iss_rd_ptr];

  always_comb begin
    be_full     = '0;
    be_nonempty = '0;
    head_err    = '0;
    for (int i = 0; i < NumBEs; i++) begin
      be_full[i]     = (be_cnt[i] == BeFullCnt);
      be_nonempty[i] = (be_cnt[i] != '0);
      head_err[i]    = be_mem[i][be_rd_ptr[i]];
    end
  end

  assign be_rsp_ready_o = ~be_full;
  assign be_push        = be_rsp_valid_i & ~be_full;

  assign out_free   = !rsp_vld_p1 || rsp_ready_i;
  assign merge      = !iss_empty && ((head_mask & ~be_nonempty) == '0) && out_free;
  assign iss_pop    = merge;
  assign be_pop     = {NumBEs{merge}} & head_mask;
  assign merge_mask = head_mask & head_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_wr_ptr <= '0;
      iss_rd_ptr <= '0;
      iss_cnt    <= '0;
      for (int i = 0; i < NumBEs; i++) begin
        be_wr_ptr[i] <= '0;
        be_rd_ptr[i] <= '0;
        be_cnt[i]    <= '0;
      end
    end else begin
      if (iss_push) iss_wr_ptr <= iss_ptr_inc(iss_wr_ptr);
      if (iss_pop)  iss_rd_ptr <= iss_ptr_inc(iss_rd_ptr);
      if (iss_push && !iss_pop)      iss_cnt <= iss_cnt + IssCntW'(1);
      else if (!iss_push && iss_pop) iss_cnt <= iss_cnt - IssCntW'(1);
      for (int i = 0; i < NumBEs; i++) begin
        if (be_push[i]) be_wr_ptr[i] <= be_ptr_inc(be_wr_ptr[i]);
        if (be_pop[i])  be_rd_ptr[i] <= be_ptr_inc(be_rd_ptr[i]);
        if (be_push[i] && !be_pop[i])      be_cnt[i] <= be_cnt[i] + BeCntW'(1);
        else if (!be_push[i] && be_pop[i]) be_cnt[i] <= be_cnt[i] - BeCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (iss_push) iss_mem[iss_wr_ptr] <= issue_mask_i;
    for (int i = 0; i < NumBEs; i++) begin
      if (be_push[i]) be_mem[i][be_wr_ptr[i]] <= be_rsp_error_i[i];
    end
  end

  // ---- stage p1: merged response register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_p1  <= 1'b0;
      rsp_err_p1  <= 1'b0;
      rsp_mask_p1 <= '0;
    end else if (merge) begin
      rsp_vld_p1  <= 1'b1;
      rsp_err_p1  <= |merge_mask;
      rsp_mask_p1 <= merge_mask;
    end else if (rsp_ready_i) begin
      rsp_vld_p1  <= 1'b0;
      rsp_err_p1  <= 1'b0;
      rsp_mask_p1 <= '0;
    end
  end

  assign rsp_valid_o    = rsp_vld_p1;
  assign rsp_error_o    = rsp_err_p1;
  assign rsp_err_mask_o = rsp_mask_p1;
  assign busy_o         = !iss_empty || rsp_vld_p1;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) iss_push |-> !iss_full)
    else $error("issue push while full");
  assert property (@(posedge clk_i) disable iff (!rst_ni) (be_push & be_full) == '0)
    else $error("back-end push while full");
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_vld_p1 && !rsp_ready_i |=> rsp_vld_p1)
    else $error("response valid dropped without ready");
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_vld_p1 && !rsp_ready_i |=> $stable(rsp_mask_p1) && $stable(rsp_err_p1))
    else $error("response payload changed under backpressure");
`endif

endmodule

// File: tb/tb_idma_mp_rsp_merge.sv
// Directed bench for idma_mp_rsp_merge: inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_idma_mp_rsp_merge;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic [3:0] issue_mask_i;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic [3:0] be_rsp_error_i;
  logic [3:0] be_rsp_valid_i;
  logic [3:0] be_rsp_ready_o;
  logic       rsp_error_o;
  logic [3:0] rsp_err_mask_o;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic       busy_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_rsp  = 0;
  int base   = 0;

  always #5 clk_i = ~clk_i;

  idma_mp_rsp_merge #(.NumBEs(4), .IssueDepth(4), .BeRspDepth(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_mask_i   (issue_mask_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .be_rsp_error_i (be_rsp_error_i),
    .be_rsp_valid_i (be_rsp_valid_i),
    .be_rsp_ready_o (be_rsp_ready_o),
    .rsp_error_o    (rsp_error_o),
    .rsp_err_mask_o (rsp_err_mask_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .busy_o         (busy_o)
  );

  always @(posedge clk_i) begin
    if (rst_ni && rsp_valid_o && rsp_ready_i) n_rsp <= n_rsp + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle();
    issue_valid_i  = 1'b0;
    be_rsp_valid_i = 4'b0000;
    be_rsp_error_i = 4'b0000;
  endtask

  initial begin
    issue_mask_i = 4'b0000;
    idle();
    rsp_ready_i = 1'b1;
    #1 rst_ni = 1'b0;
    #11;
    check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_error", {31'd0, rsp_error_o}, 32'd0);
    check("rst_mask", {28'd0, rsp_err_mask_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    #1;
    check("rst_iss_ready", {31'd0, issue_ready_o}, 32'd1);
    check("rst_be_ready", {28'd0, be_rsp_ready_o}, 32'hf);

    // single transfer M=0101, BE0 then BE2
    base = n_rsp;
    step(); issue_valid_i = 1'b1; issue_mask_i = 4'b0101; be_rsp_valid_i = 4'b0001;
    step(); issue_valid_i = 1'b0; be_rsp_valid_i = 4'b0100;
    mid();  check("t1_wait0", {31'd0, rsp_valid_o}, 32'd0);
            check("t1_busy", {31'd0, busy_o}, 32'd1);
    step(); idle();
    mid();  check("t1_wait1", {31'd0, rsp_valid_o}, 32'd0);
    step(); mid();
    check("t1_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t1_error", {31'd0, rsp_error_o}, 32'd0);
    check("t1_mask", {28'd0, rsp_err_mask_o}, 32'd0);
    step(); mid();
    check("t1_done", {31'd0, rsp_valid_o}, 32'd0);
    check("t1_idle", {31'd0, busy_o}, 32'd0);
    check("t1_count", n_rsp - base, 32'd1);

    // error merge M=1111, BE3 error
    base = n_rsp;
    step(); issue_valid_i = 1'b1; issue_mask_i = 4'b1111;
            be_rsp_valid_i = 4'b1111; be_rsp_error_i = 4'b1000;
    step(); idle();
    mid();  check("t2_wait", {31'd0, rsp_valid_o}, 32'd0);
    step(); mid();
    check("t2_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t2_error", {31'd0, rsp_error_o}, 32'd1);
    check("t2_mask", {28'd0, rsp_err_mask_o}, 32'h8);
    step(); mid();
    check("t2_count", n_rsp - base, 32'd1);

    // reordered completions: A(0001), B(0010, error), BE1 first
    base = n_rsp;
    step(); issue_valid_i = 1'b1; issue_mask_i = 4'b0001;
    step(); issue_mask_i = 4'b0010; be_rsp_valid_i = 4'b0010; be_rsp_error_i = 4'b0010;
    step(); idle();
    mid();  check("t3_hold", {31'd0, rsp_valid_o}, 32'd0);
    step(); be_rsp_valid_i = 4'b0001;
    step(); idle();
    mid();  check("t3_hold2", {31'd0, rsp_valid_o}, 32'd0);
    step(); mid();
    check("t3_a_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t3_a_mask", {28'd0, rsp_err_mask_o}, 32'h0);
    step(); mid();
    check("t3_b_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t3_b_mask", {28'd0, rsp_err_mask_o}, 32'h2);
    check("t3_b_error", {31'd0, rsp_error_o}, 32'd1);
    step(); step(); mid();
    check("t3_count", n_rsp - base, 32'd2);

    // backpressure: 4 issues M=0001 with rsp_ready_i low
    base = n_rsp;
    step(); rsp_ready_i = 1'b0; issue_valid_i = 1'b1; issue_mask_i = 4'b0001;
    repeat (4) step();
    issue_valid_i = 1'b0;
    mid();  check("t4_iss_full", {31'd0, issue_ready_o}, 32'd0);
            check("t4_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    step(); be_rsp_valid_i = 4'b0001; be_rsp_error_i = 4'b0001;
    step(); be_rsp_error_i = 4'b0000;
    step(); be_rsp_error_i = 4'b0001;
    mid();  check("t4_hold_a_mask", {28'd0, rsp_err_mask_o}, 32'h1);
            check("t4_hold_a_err", {31'd0, rsp_error_o}, 32'd1);
    step(); be_rsp_error_i = 4'b0000;
    mid();  check("t4_be_full", {28'd0, be_rsp_ready_o}, 32'he);
            check("t4_iss_room", {31'd0, issue_ready_o}, 32'd1);
    step(); idle();
    mid();  check("t4_be_blocked", {28'd0, be_rsp_ready_o}, 32'he);
            check("t4_hold_b_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("t4_hold_b_mask", {28'd0, rsp_err_mask_o}, 32'h1);
    step(); rsp_ready_i = 1'b1;
    step(); be_rsp_valid_i = 4'b0001; be_rsp_error_i = 4'b0000;
    mid();  check("t4_r2_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("t4_r2_mask", {28'd0, rsp_err_mask_o}, 32'h0);
    step(); idle();
    mid();  check("t4_r3_mask", {28'd0, rsp_err_mask_o}, 32'h1);
            check("t4_r3_err", {31'd0, rsp_error_o}, 32'd1);
    step(); mid();
    check("t4_r4_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t4_r4_mask", {28'd0, rsp_err_mask_o}, 32'h0);
    step(); mid();
    check("t4_drained", {31'd0, busy_o}, 32'd0);
    check("t4_count", n_rsp - base, 32'd4);

    // zero mask
    base = n_rsp;
    step(); issue_valid_i = 1'b1; issue_mask_i = 4'b0000;
    step(); issue_valid_i = 1'b0;
    mid();  check("t5_wait", {31'd0, rsp_valid_o}, 32'd0);
            check("t5_busy", {31'd0, busy_o}, 32'd1);
    step(); mid();
    check("t5_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("t5_error", {31'd0, rsp_error_o}, 32'd0);
    step(); mid();
    check("t5_idle", {31'd0, busy_o}, 32'd0);
    check("t5_count", n_rsp - base, 32'd1);

    // reset mid-operation
    base = n_rsp;
    step(); rsp_ready_i = 1'b0; issue_valid_i = 1'b1; issue_mask_i = 4'b0000;
    step(); issue_mask_i = 4'b0011;
    step(); idle(); be_rsp_valid_i = 4'b0001; be_rsp_error_i = 4'b0001;
    step(); idle();
    mid();  check("t6_pre_valid", {31'd0, rsp_valid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_mask", {28'd0, rsp_err_mask_o}, 32'h0);
    step(); step(); mid();
    rst_ni = 1'b1; rsp_ready_i = 1'b1;
    step(); be_rsp_valid_i = 4'b0010; be_rsp_error_i = 4'b0000;
    step(); idle();
    step(); step(); mid();
    check("t6_no_stale_rsp", n_rsp - base, 32'd0);
    check("t6_no_stale_busy", {31'd0, busy_o}, 32'd0);
    step(); issue_valid_i = 1'b1; issue_mask_i = 4'b0001;
    step(); idle();
    step(); step(); mid();
    check("t6_be0_discarded", n_rsp - base, 32'd0);
    check("t6_pending_busy", {31'd0, busy_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/idma_mp_rsp_merge.md
Name: idma_mp_rsp_merge

Overview:
- Response-side counterpart of the Mempool split/distribute mid-ends.
- The request path fans one front-end transfer out to up to NumBEs back-ends. This block collects the per-back-end completions for each issued transfer, in issue order, and emits exactly one merged response per transfer toward the front-end.
- Sits between the back-end response ports and the front-end response port. It buffers out-of-step back-end completions and OR-combines their error flags.

Parameters:
- NumBEs, 4, number of back-end response ports
- IssueDepth, 4, max outstanding issued transfers (issue FIFO depth, >=2)
- BeRspDepth, 2, per-back-end completion buffer depth (>=1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_mask_i  in  NumBEs  back-ends targeted by the transfer being issued
- issue_valid_i  in  1  issue handshake valid
- issue_ready_o  out  1  issue handshake ready
- be_rsp_error_i  in  NumBEs  per-back-end completion error flag
- be_rsp_valid_i  in  NumBEs  per-back-end completion valid
- be_rsp_ready_o  out  NumBEs  per-back-end completion ready
- rsp_error_o  out  1  merged error (OR of targeted back-end errors)
- rsp_err_mask_o  out  NumBEs  which targeted back-ends reported an error
- rsp_valid_o  out  1  merged response valid
- rsp_ready_i  in  1  merged response ready
- busy_o  out  1  any issued transfer not yet responded

Behaviour:
- Reset: single clock clk_i; reset is asynchronous, active-low, on rst_ni. All FIFOs empty. rsp_valid_o=0, rsp_error_o=0, rsp_err_mask_o=0, busy_o=0. issue_ready_o=1 and be_rsp_ready_o all 1 once reset is released. Reset mid-operation discards all pending state with no response emitted.
- Issue FIFO:
  - Depth IssueDepth; stores issue_mask_i.
  - Push on issue_valid_i&&issue_ready_o.
  - issue_ready_o = !issue_full. This is registered state only; no combinational path from the pop.
- Per-BE FIFO i:
  - Depth BeRspDepth; stores be_rsp_error_i[i].
  - Push on be_rsp_valid_i[i]&&be_rsp_ready_o[i].
  - be_rsp_ready_o[i] = !be_full[i].
- No fall-through: an entry pushed in cycle t is visible at the FIFO head from t+1.
- Merge condition (cycle c): issue FIFO non-empty with head mask M, AND every BE i with M[i]=1 is non-empty, AND (output register empty OR rsp_ready_i=1 in c).
- Merge action:
  - Pop the issue head and pop each BE FIFO with M[i]=1.
  - Load the output register at end of c: rsp_err_mask_o = M & head_errors, rsp_error_o = |rsp_err_mask_o.
  - rsp_valid_o=1 from c+1.
- BE FIFOs with M[i]=0 are untouched. Early completions for later transfers wait there.
- Mask M=0: the merge requires only the output-register condition. It yields a response with error 0.
- Output:
  - rsp_valid_o, rsp_error_o and rsp_err_mask_o are driven straight from registers.
  - They stay stable while rsp_valid_o&&!rsp_ready_i.
  - The register clears on rsp_ready_i unless a merge reloads it in the same cycle.
  - Full throughput is 1 response/cycle.
- Latency: an issue and its last back-end completion both accepted in cycle t give rsp_valid_o=1 in t+2.
- Simultaneous push and pop on the same FIFO in one cycle is legal when not full. When full, the push is blocked by ready=0.
- busy_o = issue FIFO non-empty OR output register valid.
- Occupancy counters:
  - Width $clog2(depth+1).
  - Read/write pointers wrap modulo depth; depth need not be a power of two.
- Completions are in-order per back-end. A completion arriving on BE i while no outstanding transfer targets i is buffered. It is consumed by the next issue that targets i. This is legal use by the upstream distributor, not an error.
- Assertions (sim only):
  - no push when full;
  - rsp_valid_o is not dropped without rsp_ready_i;
  - rsp payload is stable under backpressure.

Test Plan:
- Single transfer: issue M=4'b0101, then BE0 ok and BE2 ok one cycle later -> exactly one response, rsp_error_o=0, rsp_err_mask_o=0, valid 2 cycles after the BE2 handshake.
- Error merge: issue M=4'b1111, BE3 error=1, others 0 -> rsp_error_o=1, rsp_err_mask_o=4'b1000.
- Reordered completions: issue A(M=0001) then B(M=0010); BE1 completes before BE0 -> A is responded first, B in the next cycle, no extra response.
- Backpressure/full:
  - hold rsp_ready_i=0 and issue 4 transfers with M=0001 -> issue_ready_o=0 after the 4th;
  - 2 BE0 completions then be_rsp_ready_o[0]=0;
  - payload stable;
  - release -> 4 responses on consecutive cycles.
- Zero mask and busy: issue M=0000 with no BE activity -> response with error 0 two cycles after issue; busy_o returns to 0 after the handshake.
- Reset mid-operation: 2 issued, 1 completion buffered, assert rst_ni=0 -> all outputs go to reset values immediately; no response after release.
